// File: rtl/dpram_pkg.sv
// Shared types and defaults for the DPRAM host burst port.
// Imported by the interface, the read FIFO and the top level.
package dpram_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/dpram_host_port_if.sv
// Host-side burst request, write-data and read-data streams.
// The master drives requests and write data; the slave returns read data.
interface dpram_host_port_if
    import dpram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, req_we, req_addr, req_len,
        output wdata_valid, wdata, rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len,
        input  wdata_valid, wdata, rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata
    );

endinterface

// File: rtl/hp_skid_fifo.sv
// Two-entry FIFO catching RAM read data while the consumer stalls.
// Pops on an empty FIFO are ignored.
module hp_skid_fifo
    import dpram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop_i & (cnt_q != 2'd0);
    assign push_ok = push_i & ((cnt_q != 2'd2) | pop_ok);

    always_comb begin
        wr_d  = wr_q ^ push_ok;
        rd_d  = rd_q ^ pop_ok;
        cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) mem_q[wr_q] <= data_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = cnt_q != 2'd0;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/dpram_host_port.sv
// Host burst engine for RAM port A: streams write beats straight to
// the RAM and prefetches reads into a 2-entry FIFO.
module dpram_host_port
    import dpram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [ADDR_W-1:0] i_req_len,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_rdata_valid,
    input  logic              i_rdata_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ena,
    output logic              o_wea,
    output logic [ADDR_W-1:0] o_addra,
    output logic [DATA_W-1:0] o_dina,
    input  logic [DATA_W-1:0] i_douta,
    output logic              o_busy,
    output logic              o_cpu_hold,
    output logic              o_done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              we_q, we_d;
    logic              infl_q, infl_d;
    logic              hold_q, hold_d;
    logic              wea, done;
    logic              fifo_valid, pop;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;

    assign pop = fifo_valid & i_rdata_ready;

    // A word leaving this cycle frees its slot for a new issue.
    assign occ = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, infl_q};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        we_d          = we_q;
        infl_d        = 1'b0;
        hold_d        = hold_q;
        wea           = 1'b0;
        done          = 1'b0;
        o_req_ready   = 1'b0;
        o_wdata_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    we_d    = i_req_we;
                    rem_d   = i_req_len;
                    state_d = i_req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                o_wdata_ready = 1'b1;
                if (i_wdata_valid) begin
                    wea    = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            READ: begin
                if (occ < 3'd2) begin
                    infl_d = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_cnt == 2'd0 && !infl_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done && we_q) hold_d = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            infl_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            infl_q  <= infl_d;
            hold_q  <= hold_d;
        end
    end

    hp_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (infl_q),
        .data_i  (i_douta),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (o_rdata),
        .count_o (fifo_cnt)
    );

    assign o_ena         = 1'b1;
    assign o_wea         = wea;
    assign o_addra       = addr_q;
    assign o_dina        = wea ? i_wdata : '0;
    assign o_done        = done;
    assign o_busy        = state_q != IDLE;
    assign o_cpu_hold    = hold_q;
    assign o_rdata_valid = fifo_valid;

endmodule

// File: tb/tb_dpram_host_port.sv
// Scoreboard bench: a behavioural RAM plus a shadow memory predict
// every write beat and every returned read word.
module tb_dpram_host_port;
    import dpram_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          ena, wea, busy, hold, done;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina, douta;

    dpram_host_port_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();

    dpram_host_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (hif.req_valid),
        .o_req_ready   (hif.req_ready),
        .i_req_we      (hif.req_we),
        .i_req_addr    (hif.req_addr),
        .i_req_len     (hif.req_len),
        .i_wdata_valid (hif.wdata_valid),
        .o_wdata_ready (hif.wdata_ready),
        .i_wdata       (hif.wdata),
        .o_rdata_valid (hif.rdata_valid),
        .i_rdata_ready (hif.rdata_ready),
        .o_rdata       (hif.rdata),
        .o_ena         (ena),
        .o_wea         (wea),
        .o_addra       (addra),
        .o_dina        (dina),
        .i_douta       (douta),
        .o_busy        (busy),
        .o_cpu_hold    (hold),
        .o_done        (done)
    );

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    int            run = 0;
    int            max_run = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM port A: write on wea, registered read one cycle later.
    always @(posedge clk) begin
        if (ena && wea) ram[addra] <= dina;
        douta <= ram[addra];
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wea) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got write at %0h", addra);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", addra, w.a);
                check("wr_data", dina, w.d);
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (hif.rdata_valid && hif.rdata_ready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got %0h", hif.rdata);
            end else begin
                check("rd_data", hif.rdata, rq.pop_front());
            end
        end
        if (done) done_cnt++;
    end

    task automatic do_req(input bit we, input int addr, input int len);
        bit ok = 0;
        hif.req_we    = we;
        hif.req_addr  = AW'(addr);
        hif.req_len   = AW'(len);
        hif.req_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (hif.req_ready) ok = 1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no ready, required accept");
        end
        hif.req_valid = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len,
                               input bit gaps, input bit rnd,
                               input logic [DW-1:0] pat);
        do_req(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            wr_t w;
            while (gaps && $urandom_range(0, 3) == 0) begin
                hif.wdata_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            w.a = AW'(addr + i);
            w.d = rnd ? $urandom : pat + DW'(i);
            hif.wdata       = w.d;
            hif.wdata_valid = 1'b1;
            wq.push_back(w);
            ref_mem[w.a] = w.d;
            @(negedge clk);
            check("wr_done_pulse", done, (i == len));
            @(posedge clk);
            #1;
        end
        hif.wdata_valid = 1'b0;
        exp_done++;
    endtask

    task automatic read_burst(input int addr, input int len,
                              input int mode, output int cyc);
        bit idle = 0;
        cyc = 0;
        for (int i = 0; i <= len; i++) rq.push_back(ref_mem[AW'(addr + i)]);
        do_req(1'b0, addr, len);
        while (rq.size() > 0 && cyc < 5000) begin
            case (mode)
                0:       hif.rdata_ready = 1'b1;
                1:       hif.rdata_ready = (cyc % 2 == 0);
                default: hif.rdata_ready = 1'($urandom);
            endcase
            @(posedge clk);
            #1;
            cyc++;
        end
        if (rq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout: got %0d words left, required 0", rq.size());
            rq.delete();
        end
        hif.rdata_ready = 1'b1;
        for (int t = 0; t < 20 && !idle; t++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        check("rd_burst_ends", idle, 1);
        @(posedge clk);
        #1;
        exp_done++;
    endtask

    initial begin
        int cyc;
        int d0;
        int base;
        bit ok;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        rst              = 1'b1;
        hif.req_valid    = 1'b0;
        hif.req_we       = 1'b0;
        hif.req_addr     = '0;
        hif.req_len      = '0;
        hif.wdata_valid  = 1'b0;
        hif.wdata        = '0;
        hif.rdata_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hold", hold, 1);
        check("rst_wea", wea, 0);
        check("rst_addra", addra, 0);
        check("rst_dina", dina, 0);
        check("rst_rvalid", hif.rdata_valid, 0);
        check("rst_done", done, 0);
        check("rst_ena", ena, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single write, CPU released afterwards
        write_burst(9'h1A5, 0, 0, 0, 32'hDEADBEEF);
        @(negedge clk);
        check("hold_after_wr", hold, 0);
        @(posedge clk);
        #1;

        // wrap-around write then read
        write_burst(9'h1FE, 3, 0, 0, 32'hA000_0000);
        read_burst(9'h1FE, 3, 0, cyc);

        // toggled read backpressure
        write_burst(9'h040, 7, 1, 1, '0);
        read_burst(9'h040, 7, 1, cyc);

        // held request and stray write data during a read
        base = int'($urandom_range(0, DEPTH - 1));
        for (int i = 0; i <= 7; i++) rq.push_back(ref_mem[AW'(base + i)]);
        do_req(1'b0, base, 7);
        hif.req_valid   = 1'b1;
        hif.req_we      = 1'b1;
        hif.req_addr    = 9'h123;
        hif.req_len     = '0;
        hif.wdata       = 32'h5A5A_1234;
        hif.wdata_valid = 1'b1;
        for (int t = 0; t < 200 && rq.size() > 0; t++) begin
            @(negedge clk);
            check("held_req_ready", hif.req_ready, 0);
        end
        begin
            wr_t w;
            w.a = 9'h123;
            w.d = 32'h5A5A_1234;
            wq.push_back(w);
            ref_mem[w.a] = w.d;
        end
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (hif.req_ready) ok = 1;
        end
        check("held_req_accept", ok, 1);
        @(posedge clk);
        #1;
        hif.req_valid = 1'b0;
        @(posedge clk);
        #1;
        hif.wdata_valid = 1'b0;
        exp_done += 2;

        // full-depth burst at line rate
        max_run = 0;
        d0 = done_cnt;
        write_burst(0, DEPTH - 1, 0, 1, '0);
        @(negedge clk);
        check("wr512_run", max_run, DEPTH);
        check("wr512_done", done_cnt - d0, 1);
        @(posedge clk);
        #1;
        d0 = done_cnt;
        read_burst(0, DEPTH - 1, 0, cyc);
        check("rd512_rate", cyc <= DEPTH + 4, 1);
        check("rd512_done", done_cnt - d0, 1);

        // random bursts
        for (int n = 0; n < 8; n++) begin
            int a = int'($urandom_range(0, DEPTH - 1));
            int l = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) write_burst(a, l, 1, 1, '0);
            else read_burst(a, l, int'($urandom_range(0, 2)), cyc);
        end

        // reset in the middle of a write burst
        base = 9'h0F0;
        d0 = done_cnt;
        do_req(1'b1, base, 9);
        for (int i = 0; i < 3; i++) begin
            wr_t w;
            w.a = AW'(base + i);
            w.d = $urandom;
            hif.wdata       = w.d;
            hif.wdata_valid = 1'b1;
            wq.push_back(w);
            ref_mem[w.a] = w.d;
            @(posedge clk);
            #1;
        end
        hif.wdata = ~ref_mem[AW'(base + 3)];
        rst = 1'b1;
        @(negedge clk);
        check("abort_wea", wea, 0);
        check("abort_busy", busy, 0);
        check("abort_hold", hold, 1);
        check("abort_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hif.wdata_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", ram[AW'(base + 3)], ref_mem[AW'(base + 3)]);
        check("abort_prev_write", ram[AW'(base + 2)], ref_mem[AW'(base + 2)]);
        check("abort_no_done", done_cnt - d0, 0);

        repeat (5) @(posedge clk);
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        check("done_count", done_cnt, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
